// File: rtl/sine_seq_ctrl_if.sv
// Control, ROM and modulator-side signals of the sine-table sample sequencer.
// The slave modport is the sequencer; master is whoever drives it (host, ROM, modulator).
interface sine_seq_ctrl_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OSR_W  = 8
);
  logic              start;
  logic              stop;
  logic [OSR_W-1:0]  osr;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              sample_ready;
  logic              busy;
  logic              underrun;

  modport master (
    output start, stop, osr, step, rom_data, sample_ready,
    input  rom_addr, sample_out, sample_valid, busy, underrun
  );

  modport slave (
    input  start, stop, osr, step, rom_data, sample_ready,
    output rom_addr, sample_out, sample_valid, busy, underrun
  );
endinterface

// File: rtl/sine_seq_ctrl.sv
// Walks a synchronous sine ROM at a programmable step and period, offering each
// sample over valid/ready; supports graceful stop at table wrap and sticky underrun.
module sine_seq_ctrl #(
  parameter int unsigned TABLE_LEN = 30,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned OSR_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  sine_seq_ctrl_if.slave  bus
);
  localparam int unsigned SUM_W = ADDR_W + 1;
  localparam logic [SUM_W-1:0] LEN_S = SUM_W'(TABLE_LEN);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, OFFER, PACE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] step_q;
  logic [OSR_W-1:0]  p_m1;
  logic [OSR_W-1:0]  cnt;
  logic              stop_pend;
  logic [DATA_W-1:0] sample_q;

  logic              tick_c;
  logic [SUM_W-1:0]  sum_c;
  logic              wrap_c;
  logic [ADDR_W-1:0] next_index_c;
  logic [ADDR_W-1:0] step_c;
  logic [OSR_W-1:0]  pm1_c;

  // Period tick, index advance with modulo wrap, and sanitised start parameters.
  always_comb begin
    tick_c       = (state != IDLE) && (cnt == p_m1);
    sum_c        = {1'b0, index} + {1'b0, step_q};
    wrap_c       = (sum_c >= LEN_S);
    next_index_c = wrap_c ? ADDR_W'(sum_c - LEN_S) : sum_c[ADDR_W-1:0];
    step_c       = ((bus.step == '0) || ({1'b0, bus.step} >= LEN_S))
                   ? ADDR_W'(1) : bus.step;
    pm1_c        = (bus.osr == '0) ? '0 : bus.osr - OSR_W'(1);
  end

  assign bus.sample_out = sample_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      index            <= '0;
      step_q           <= ADDR_W'(1);
      p_m1             <= '0;
      cnt              <= '0;
      stop_pend        <= 1'b0;
      sample_q         <= '0;
      bus.rom_addr     <= '0;
      bus.sample_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.underrun     <= 1'b0;
    end else begin
      // Free-running period counter and drop detection while busy.
      if (state != IDLE) begin
        cnt <= tick_c ? '0 : cnt + OSR_W'(1);
        if (bus.stop) stop_pend <= 1'b1;
        if (tick_c && (state != PACE)) bus.underrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            p_m1         <= pm1_c;
            step_q       <= step_c;
            index        <= '0;
            bus.underrun <= 1'b0;
            stop_pend    <= 1'b0;
            cnt          <= '0;
            bus.rom_addr <= '0;
            bus.busy     <= 1'b1;
            state        <= FETCH;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          sample_q         <= bus.rom_data;
          bus.sample_valid <= 1'b1;
          state            <= OFFER;
        end
        OFFER: begin
          if (bus.sample_ready) begin
            bus.sample_valid <= 1'b0;
            // Graceful stop only at a table wrap, so restart lands on the zero crossing.
            if (stop_pend && wrap_c) begin
              sample_q <= '0;
              index    <= '0;
              cnt      <= '0;
              bus.busy <= 1'b0;
              state    <= IDLE;
            end else begin
              index <= next_index_c;
              state <= PACE;
            end
          end
        end
        PACE: begin
          if (tick_c) begin
            bus.rom_addr <= index;
            state        <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sine_seq_ctrl.sv
// Directed bench for sine_seq_ctrl: pacing, stepping, backpressure, graceful stop,
// P=1 underrun and asynchronous reset, against a 30-entry sine ROM model.
module tb_sine_seq_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  sine_seq_ctrl_if #(.ADDR_W(5), .DATA_W(8), .OSR_W(8)) bus ();

  sine_seq_ctrl #(.TABLE_LEN(30), .ADDR_W(5), .DATA_W(8), .OSR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int sin_tab [30] = '{0, 16, 31, 45, 57, 67, 73, 77, 77, 73, 67, 57, 45, 31, 16,
                       0, -16, -31, -45, -57, -67, -73, -77, -77, -73, -67, -57, -45, -31, -16};
  logic [7:0] rom [32];
  int addr_seq [7] = '{0, 7, 14, 21, 28, 5, 12};

  // Synchronous ROM: data one cycle after address.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && bus.sample_valid !== 1'b1; i++) cyc(1);
    chk("valid_timeout", 32'(bus.sample_valid), 32'd1);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    cyc(1);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge of the first FETCH cycle.
  task automatic start_run(input logic [7:0] o, input logic [4:0] s);
    bus.osr = o;
    bus.step = s;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = (i < 30) ? 8'(sin_tab[i]) : 8'h00;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.osr = '0;
    bus.step = '0;
    bus.sample_ready = 1'b1;
    cyc(2);
    chk("rst_addr",  32'(bus.rom_addr), 32'd0);
    chk("rst_samp",  32'(bus.sample_out), 32'd0);
    chk("rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_under", 32'(bus.underrun), 32'd0);
    rst = 1'b0;
    cyc(1);

    // Basic pacing: P=4, step=1.
    start_run(8'd4, 5'd1);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_addr0", 32'(bus.rom_addr), 32'd0);
    cyc(1);
    chk("t1_wait_nv", 32'(bus.sample_valid), 32'd0);
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", 32'(bus.sample_valid), 32'd1);
      chk("t1_samp", 32'(bus.sample_out), 32'(rom[k]));
      cyc(1);
      chk("t1_gap", 32'(bus.sample_valid), 32'd0);
      cyc(3);
    end
    chk("t1_under", 32'(bus.underrun), 32'd0);

    // step=7 address walk with wrap.
    do_reset();
    start_run(8'd4, 5'd7);
    for (int j = 0; j < 7; j++) begin
      chk("t2_addr", 32'(bus.rom_addr), 32'(addr_seq[j]));
      cyc(4);
    end

    // step=0 and step>=TABLE_LEN both behave as step=1.
    do_reset();
    start_run(8'd4, 5'd0);
    chk("t2_s0_a0", 32'(bus.rom_addr), 32'd0);
    cyc(4);
    chk("t2_s0_a1", 32'(bus.rom_addr), 32'd1);
    do_reset();
    start_run(8'd4, 5'd30);
    cyc(4);
    chk("t2_s30_a1", 32'(bus.rom_addr), 32'd1);
    cyc(4);
    chk("t2_s30_a2", 32'(bus.rom_addr), 32'd2);

    // Backpressure for 6 cycles on the second offer.
    do_reset();
    start_run(8'd4, 5'd1);
    cyc(5);
    bus.sample_ready = 1'b0;
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      chk("t3_hold_v", 32'(bus.sample_valid), 32'd1);
      chk("t3_hold_s", 32'(bus.sample_out), 32'(rom[1]));
      cyc(1);
    end
    chk("t3_under", 32'(bus.underrun), 32'd1);
    bus.sample_ready = 1'b1;
    cyc(1);
    chk("t3_taken", 32'(bus.sample_valid), 32'd0);
    wait_valid(20);
    chk("t3_next", 32'(bus.sample_out), 32'(rom[2]));

    // Graceful stop requested at index 10, completes after index 29.
    do_reset();
    bus.sample_ready = 1'b0;
    start_run(8'd4, 5'd1);
    cyc(6);
    bus.sample_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      wait_valid(20);
      chk("t4_samp", 32'(bus.sample_out), 32'(rom[k]));
      cyc(1);
      if (k == 9) begin
        bus.stop = 1'b1;
        cyc(1);
        bus.stop = 1'b0;
      end
    end
    chk("t4_busy", 32'(bus.busy), 32'd0);
    chk("t4_zero", 32'(bus.sample_out), 32'd0);
    chk("t4_nv", 32'(bus.sample_valid), 32'd0);
    chk("t4_under_pre", 32'(bus.underrun), 32'd1);
    start_run(8'd4, 5'd1);
    chk("t4_under_clr", 32'(bus.underrun), 32'd0);
    chk("t4_re_addr", 32'(bus.rom_addr), 32'd0);
    cyc(2);
    chk("t4_re_v", 32'(bus.sample_valid), 32'd1);
    chk("t4_re_s", 32'(bus.sample_out), 32'(rom[0]));

    // P=1: underrun from the second busy cycle, order preserved.
    do_reset();
    start_run(8'd0, 5'd1);
    chk("t5_under_c1", 32'(bus.underrun), 32'd0);
    cyc(1);
    chk("t5_under_c2", 32'(bus.underrun), 32'd1);
    for (int k = 0; k < 5; k++) begin
      wait_valid(10);
      chk("t5_samp", 32'(bus.sample_out), 32'(rom[k]));
      cyc(1);
    end

    // Asynchronous reset in the middle of an offer.
    do_reset();
    start_run(8'd4, 5'd1);
    cyc(5);
    bus.sample_ready = 1'b0;
    cyc(1);
    chk("t6_pre_v", 32'(bus.sample_valid), 32'd1);
    chk("t6_pre_s", 32'(bus.sample_out), 32'(rom[1]));
    chk("t6_pre_a", 32'(bus.rom_addr), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_v", 32'(bus.sample_valid), 32'd0);
    chk("t6_s", 32'(bus.sample_out), 32'd0);
    chk("t6_a", 32'(bus.rom_addr), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_under", 32'(bus.underrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.sample_ready = 1'b1;
    cyc(1);
    start_run(8'd4, 5'd1);
    chk("t6_re_addr", 32'(bus.rom_addr), 32'd0);
    chk("t6_re_busy", 32'(bus.busy), 32'd1);
    cyc(2);
    chk("t6_re_s", 32'(bus.sample_out), 32'(rom[0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sine_seq_ctrl.md
# sine_seq_ctrl

Sample-sequencing controller for the sine-table DAC path. Walks a synchronous waveform ROM at a programmable index step and sample period, and offers each sample to the delta-sigma modulator over a valid/ready handshake. Provides graceful stop at the table wrap (zero crossing) and a sticky underrun flag. It sits between the waveform table and the modulator input.

## Interface
- TABLE_LEN, 30, number of ROM entries; index 0 holds the zero-crossing sample
- ADDR_W, 5, ROM address width; 2^ADDR_W >= TABLE_LEN
- DATA_W, 8, sample width, two's complement
- OSR_W, 8, width of the sample-period input

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; ignored unless IDLE
- stop  in  1  one-cycle pulse; requests graceful stop; ignored in IDLE
- osr  in  OSR_W  sample period P in clk cycles; P = max(osr,1); sampled at start
- step  in  ADDR_W  index increment; 0 treated as 1; values >= TABLE_LEN treated as 1; sampled at start
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM data, valid one cycle after rom_addr
- sample_out  out  DATA_W  sample to modulator
- sample_valid  out  1  sample_out valid
- sample_ready  in  1  modulator accepts when valid&ready
- busy  out  1  high in every state except IDLE
- underrun  out  1  sticky; set by a dropped tick; cleared by accepted start

## Operation
- Reset values: rom_addr=0, sample_out=0, sample_valid=0, busy=0, underrun=0; state IDLE; index=0; stop_pend=0; period counter=0.
- States: IDLE, FETCH, WAIT, OFFER, PACE.
- IDLE + start: latch P and step; index=0; clear underrun and stop_pend; counter=0; go to FETCH.
- FETCH: rom_addr=index; go to WAIT.
- WAIT: capture rom_data into the sample register at the end of this cycle; go to OFFER.
- OFFER: sample_valid=1, sample_out stable. On valid&ready: index = index+step, minus TABLE_LEN if the sum >= TABLE_LEN (compute the sum in ADDR_W+1 bits). Then go to PACE. Exception: if stop_pend=1 and the sum wrapped (>= TABLE_LEN), go to IDLE, force sample_out=0, and reset index to 0.
- PACE: on tick, go to FETCH; otherwise hold.
- Period counter: runs while busy. It increments each cycle and wraps from P-1 to 0. It is 0 in the first FETCH cycle. tick = (counter == P-1).
- A tick in any state other than PACE is dropped and sets underrun. The sequence continues and the next fetch waits for the following tick.
- stop sets stop_pend; stop arriving in any busy state is honoured at the next wrapping acceptance.
- start while busy: ignored, no state change.
- sample_out holds the last captured sample between offers; it is 0 after a graceful stop.
- rst at any time: all state returns to the reset values asynchronously. There is no partial completion.

## Timing
- start sampled at edge N: FETCH in cycle N+1 (rom_addr=0), WAIT in N+2, sample_valid=1 from N+3.
- With ready=1, acceptance happens in the first OFFER cycle. One sample is emitted every P cycles: valid in cycles N+3+kP.
- Minimum underrun-free P = 4 with ready constantly high. P <= 3 underruns every period.
- Stop latency: completes in the cycle after the wrapping acceptance. busy=0 and sample_out=0 from that cycle.
- Graceful stop always ends at a table wrap, so the next start resumes at index 0 (a zero sample).

## Test plan
- ROM model with 30 entries {0,16,31,…,-16}, osr=4, step=1, ready=1, start at N: valid at N+3, N+7, …; samples 0,16,31,45; underrun stays 0.
- step=7, osr=4: rom_addr sequence 0,7,14,21,28,5,12 (wrap 35-30=5).
- osr=4, ready held low for 6 cycles during an OFFER: sample_out is stable and valid stays high; underrun=1; after ready rises, the next sample is taken from the next index, with no duplicate and no skip.
- step=1, stop pulsed while index=10: emission continues through index 29, then busy=0, sample_out=0 the cycle after accepting index 29; restart emits 0 first and underrun is cleared.
- osr=0 (P=1), step=1: underrun=1 in the second busy cycle; samples are still delivered in table order.
- rst asserted mid-OFFER: outputs go to their reset values immediately, without waiting for a clock edge; start after release begins at rom_addr=0.
